// File: rtl/result_recorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : result_recorder_pkg
//  Description : Shared types and default sizes for the result recorder.
//                Provides the recorder state enum and default WIDTH/DEPTH.
//  Revision    : 1.0  initial release
// ============================================================================
package result_recorder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 256;

  // IDLE: empty and accepting; REC: partially filled and accepting;
  // DONE: run finished, no longer accepting until clear.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/result_recorder_rec_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rec_ram
//  Description : Simple dual-port synchronous RAM. One write port, one
//                registered read port. The array has no reset; masking of
//                unwritten entries is done by the caller.
//  Ports       : clk    - clock
//                we     - write enable
//                waddr  - write address
//                wdata  - write data
//                raddr  - read address
//                rdata  - registered read data (1-cycle latency)
//  Revision    : 1.0  initial release
// ============================================================================
module rec_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Read returns the pre-write contents on an address collision.
  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/result_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : result_recorder
//  Description : Streaming result sink. Captures words from a valid/ready
//                stream into a RAM in arrival order and serves them back
//                through an addr/data read port with 1-cycle latency.
//                Recording stops on in_last or when full; clear restarts.
//  Ports       : clk, rst (async, active-low), clear (sync restart)
//                in_valid/in_data/in_last/in_ready - input stream
//                addr/data  - readback port, data masked to 0 at/above count
//                count      - words recorded (0..DEPTH)
//                done, full - run status
//                checksum   - running sum of recorded words
//  Options     : RESULT_RECORDER_CHECKSUM_EN builds the checksum
//                accumulator; otherwise checksum is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module result_recorder
  import result_recorder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              full,
  output logic [WIDTH-1:0]  checksum
);

  localparam logic [ADDR_W:0] C_DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t           state_q, state_d;
  logic [ADDR_W:0]  count_q, count_d;
  logic             rd_ok_q, rd_ok_d;
  logic             w_xfer;
  logic [WIDTH-1:0] w_ram_rdata;

  assign in_ready = (state_q != ST_DONE) && !clear;
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (w_xfer) begin
      count_d = count_q + 1'b1;
      if (in_last || (count_d == C_DEPTH_CNT)) begin
        state_d = ST_DONE;
      end else begin
        state_d = ST_REC;
      end
    end
  end

  // Qualifies the read with the pre-edge count; a same-cycle write to
  // addr is therefore not yet visible and reads back as 0.
  always_comb begin
    rd_ok_d = ({1'b0, addr} < count_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  rec_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rec_ram (
    .clk   (clk),
    .we    (w_xfer),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (addr),
    .rdata (w_ram_rdata)
  );

  assign data  = rd_ok_q ? w_ram_rdata : '0;
  assign count = count_q;
  assign done  = (state_q == ST_DONE);
  assign full  = (count_q == C_DEPTH_CNT);

`ifdef RESULT_RECORDER_CHECKSUM_EN
  logic [WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (clear) begin
      checksum_d = '0;
    end else if (w_xfer) begin
      checksum_d = checksum_q + in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_result_recorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_recorder
//  Description : Directed self-checking bench for result_recorder (DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_result_recorder;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] addr = '0;
  logic [WIDTH-1:0]  data;
  logic [ADDR_W:0]   count;
  logic              done;
  logic              full;
  logic [WIDTH-1:0]  checksum;

  int n_checks = 0;
  int n_errors = 0;

  result_recorder #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .addr     (addr),
    .data     (data),
    .count    (count),
    .done     (done),
    .full     (full),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [WIDTH-1:0] exp_sum;

  initial begin
    // Reset values
    #3;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_csum", checksum, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Three words, last on the third
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    push(32'h33, 1'b1);
    check("t1_count", 32'(count), 32'd3);
    check("t1_done", 32'(done), 32'd1);
    check("t1_ready", 32'(in_ready), 32'd0);
    check("t1_full", 32'(full), 32'd0);
    // Valid in DONE is ignored
    push(32'h99, 1'b0);
    check("t1_count_hold", 32'(count), 32'd3);
    addr = 2'd0; tick(); check("t1_rd0", data, 32'h11);
    addr = 2'd1; tick(); check("t1_rd1", data, 32'h22);
    addr = 2'd2; tick(); check("t1_rd2", data, 32'h33);
    addr = 2'd3; tick(); check("t1_rd3", data, 32'h0);

    // Fill: six words offered, only four accepted
    do_clear();
    check("t2_clr_count", 32'(count), 32'd0);
    check("t2_clr_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + 32'(i);
      #1;
      check($sformatf("t2_ready%0d", i), 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    check("t2_count", 32'(count), 32'd4);
    check("t2_full", 32'(full), 32'd1);
    check("t2_done", 32'(done), 32'd1);
    addr = 2'd3; tick(); check("t2_rd3", data, 32'h103);
    addr = 2'd0; tick(); check("t2_rd0", data, 32'h100);

    // Toggling valid, clear colliding with valid
    do_clear();
    check("t3_full_clr", 32'(full), 32'd0);
    push(32'hA1, 1'b0);
    check("t3_count1", 32'(count), 32'd1);
    tick();
    push(32'hA2, 1'b0);
    check("t3_count2", 32'(count), 32'd2);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBB;
    #1;
    check("t3_ready_clr", 32'(in_ready), 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t3_count_clr", 32'(count), 32'd0);
    tick();
    push(32'hC1, 1'b0);
    check("t3_count3", 32'(count), 32'd1);
    addr = 2'd0; tick(); check("t3_rd0", data, 32'hC1);
    addr = 2'd1; tick(); check("t3_rd1", data, 32'h0);

    // Same-cycle write and read of address 2
    do_clear();
    push(32'h11, 1'b0);
    push(32'h22, 1'b0);
    addr = 2'd2;
    push(32'h33, 1'b0);
    check("t4_rd_collide", data, 32'h0);
    check("t4_count", 32'(count), 32'd3);
    tick();
    check("t4_rd_after", data, 32'h33);

    // Checksum wraps modulo 2^WIDTH
    do_clear();
    check("t5_csum_clr", checksum, 32'd0);
    push(32'hFFFF_FFFF, 1'b0);
    push(32'h0000_0002, 1'b0);
`ifdef RESULT_RECORDER_CHECKSUM_EN
    exp_sum = 32'h0000_0001;
`else
    exp_sum = 32'h0000_0000;
`endif
    check("t5_csum", checksum, exp_sum);

    // Asynchronous reset mid-run
    do_clear();
    push(32'h55, 1'b0);
    push(32'h66, 1'b0);
    addr = 2'd0;
    tick();
    check("t6_pre_rd0", data, 32'h55);
    #2;
    rst = 1'b0;
    #1;
    check("t6_ready", 32'(in_ready), 32'd1);
    check("t6_count", 32'(count), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_full", 32'(full), 32'd0);
    check("t6_data", data, 32'd0);
    check("t6_csum", checksum, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    addr = 2'd0; tick(); check("t6_rd0", data, 32'h0);
    addr = 2'd1; tick(); check("t6_rd1", data, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
